// File: rtl/pattern_frame_gen_if.sv
// Video stream bundle: run control in, frame/line/data valids and pixel out.
interface pattern_frame_gen_if;
  logic       en;
  logic [2:0] sel;
  logic       fval;
  logic       lval;
  logic       dval;
  logic [7:0] pix_data;
  logic       frame_done;
  logic       busy;

  // Generator side.
  modport master (
    input  en,
    input  sel,
    output fval,
    output lval,
    output dval,
    output pix_data,
    output frame_done,
    output busy
  );

  // Consumer side.
  modport slave (
    output en,
    output sel,
    input  fval,
    input  lval,
    input  dval,
    input  pix_data,
    input  frame_done,
    input  busy
  );
endinterface

// File: rtl/pattern_frame_gen.sv
// Camera-link style test-pattern frame generator: fval/lval/dval timing plus
// a selectable 8-bit pattern. Outputs are loaded from next-state values so
// every output is a flop and they all move on the same edge.
module pattern_frame_gen #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned V_BLANK   = 32,
  parameter int unsigned FV_LV_GAP = 4,
  parameter int unsigned BAR_W     = 80,
  parameter int unsigned BAR_H     = 60
) (
  input logic                 clk,
  input logic                 rst,
  pattern_frame_gen_if.master io_vid
);

  localparam int unsigned HvMax  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned CntMax = (HvMax > FV_LV_GAP) ? HvMax : FV_LV_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] GapLast  = CntW'(FV_LV_GAP - 1);
  localparam logic [CntW-1:0] HBlkLast = CntW'(H_BLANK - 1);
  localparam logic [CntW-1:0] VBlkLast = CntW'(V_BLANK - 1);
  localparam logic [11:0]     XLast    = 12'(WIDTH - 1);
  localparam logic [11:0]     YLast    = 12'(HEIGHT - 1);
  localparam logic [11:0]     BxLast   = 12'(BAR_W - 1);
  localparam logic [11:0]     ByLast   = 12'(BAR_H - 1);

  typedef enum logic [2:0] {StIdle, StFvPre, StLine, StHBlk, StFvPost, StVBlk} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [11:0]     r_x, w_x_nxt, r_y, w_y_nxt;
  logic [11:0]     r_bx, w_bx_nxt, r_sx, w_sx_nxt;   // pixel within strap, strap index
  logic [11:0]     r_by, w_by_nxt, r_sy, w_sy_nxt;   // line within bar, bar index
  logic [2:0]      r_sel, w_sel_nxt;
  logic            w_start, w_done_nxt;
  logic [5:0]      w_diff;
  logic [7:0]      w_pix_nxt;

  logic            r_fval, r_lval, r_frame_done, r_busy;
  logic [7:0]      r_pix;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_bx    <= '0;
      r_sx    <= '0;
      r_by    <= '0;
      r_sy    <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_bx    <= w_bx_nxt;
      r_sx    <= w_sx_nxt;
      r_by    <= w_by_nxt;
      r_sy    <= w_sy_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_bx_nxt    = r_bx;
    w_sx_nxt    = r_sx;
    w_by_nxt    = r_by;
    w_sy_nxt    = r_sy;
    w_sel_nxt   = r_sel;
    w_start     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_vid.en) w_start = 1'b1;
      end
      StFvPre: begin
        if (r_cnt == GapLast) begin
          w_state_nxt = StLine;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StLine: begin
        if (r_x == XLast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_y == YLast) ? StFvPost : StHBlk;
        end else begin
          w_x_nxt = r_x + 1'b1;
          if (r_bx == BxLast) begin
            w_bx_nxt = '0;
            w_sx_nxt = r_sx + 1'b1;
          end else begin
            w_bx_nxt = r_bx + 1'b1;
          end
        end
      end
      StHBlk: begin
        if (r_cnt == HBlkLast) begin
          w_state_nxt = StLine;
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_bx_nxt    = '0;
          w_sx_nxt    = '0;
          w_y_nxt     = r_y + 1'b1;
          if (r_by == ByLast) begin
            w_by_nxt = '0;
            w_sy_nxt = r_sy + 1'b1;
          end else begin
            w_by_nxt = r_by + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StFvPost: begin
        if (r_cnt == GapLast) begin
          w_state_nxt = StVBlk;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StVBlk: begin
        if (r_cnt == VBlkLast) begin
          if (io_vid.en) w_start = 1'b1;
          else           w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // Frame start: clear all position counters and latch the pattern select.
    if (w_start) begin
      w_state_nxt = StFvPre;
      w_cnt_nxt   = '0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_bx_nxt    = '0;
      w_sx_nxt    = '0;
      w_by_nxt    = '0;
      w_sy_nxt    = '0;
      w_sel_nxt   = io_vid.sel;
    end
  end

  // Pattern for the pixel that will be presented next cycle; zero outside lines.
  always_comb begin
    w_pix_nxt = 8'd0;
    w_diff    = w_x_nxt[5:0] - w_y_nxt[5:0];
    if (w_state_nxt == StLine) begin
      case (w_sel_nxt)
        3'b000:  w_pix_nxt = (w_sx_nxt > 12'd7) ? 8'hFF : {w_sx_nxt[2:0], 5'd0};
        3'b001:  w_pix_nxt = (w_sy_nxt > 12'd7) ? 8'hFF : {w_sy_nxt[2:0], 5'd0};
        3'b010:  w_pix_nxt = w_x_nxt[7:0] + w_y_nxt[7:0];
        3'b011:  w_pix_nxt = (w_x_nxt[5] ^ w_y_nxt[5]) ? 8'hFF : 8'h00;
        3'b110:  w_pix_nxt = (w_x_nxt[6] ^ w_y_nxt[6]) ? w_x_nxt[7:0] : w_y_nxt[7:0];
        3'b111:  w_pix_nxt = (w_diff[5:3] == 3'd0) ? 8'hFF : 8'd64;
        default: w_pix_nxt = 8'd0;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fval       <= 1'b0;
      r_lval       <= 1'b0;
      r_pix        <= 8'd0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_fval       <= (w_state_nxt == StFvPre) || (w_state_nxt == StLine) ||
                      (w_state_nxt == StHBlk)  || (w_state_nxt == StFvPost);
      r_lval       <= (w_state_nxt == StLine);
      r_pix        <= w_pix_nxt;
      r_frame_done <= w_done_nxt;
      r_busy       <= (w_state_nxt != StIdle);
    end
  end

  assign io_vid.fval       = r_fval;
  assign io_vid.lval       = r_lval;
  assign io_vid.dval       = r_lval;
  assign io_vid.pix_data   = r_pix;
  assign io_vid.frame_done = r_frame_done;
  assign io_vid.busy       = r_busy;

endmodule

// File: tb/tb_pattern_frame_gen.sv
// Directed bench for pattern_frame_gen with a tiny 8x4 frame.
module tb_pattern_frame_gen;

  logic clk = 1'b0;
  logic rst;
  pattern_frame_gen_if vid ();

  pattern_frame_gen #(
    .WIDTH    (8),
    .HEIGHT   (4),
    .H_BLANK  (2),
    .V_BLANK  (3),
    .FV_LV_GAP(1),
    .BAR_W    (2),
    .BAR_H    (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_vid(vid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run statistics gathered by watch().
  int g_pix [0:7][0:7];
  int g_len [0:7];
  int fval_cnt, busy_cnt, bursts, done_cnt, zero_viol, dval_viol, fval_rises;
  int done_at, rise2_at;
  int exp_line [8];

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_line(input string tag, input int line, input int exp [8]);
    for (int c = 0; c < 8; c++) check($sformatf("%s[%0d]", tag, c), g_pix[line][c], exp[c]);
  endtask

  // Sample outputs on falling edges for ncyc cycles; optionally drop en or
  // change sel after a given sample index.
  task automatic watch(input int ncyc, input int en_off_at, input int sel_at,
                       input logic [2:0] sel_new);
    logic prev_lval = 1'b0;
    logic prev_fval = 1'b0;
    fval_cnt = 0; busy_cnt = 0; bursts = 0; done_cnt = 0; zero_viol = 0;
    dval_viol = 0; fval_rises = 0; done_at = -1; rise2_at = -1;
    for (int l = 0; l < 8; l++) begin
      g_len[l] = 0;
      for (int c = 0; c < 8; c++) g_pix[l][c] = -1;
    end
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (vid.fval) fval_cnt++;
      if (vid.busy) busy_cnt++;
      if (vid.lval && !prev_lval) bursts++;
      if (vid.lval) begin
        if (bursts >= 1 && bursts <= 8) begin
          if (g_len[bursts-1] < 8) g_pix[bursts-1][g_len[bursts-1]] = int'(vid.pix_data);
          g_len[bursts-1]++;
        end
      end else if (vid.pix_data != 8'd0) begin
        zero_viol++;
      end
      if (vid.dval != vid.lval) dval_viol++;
      if (vid.frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (vid.fval && !prev_fval) begin
        fval_rises++;
        if (fval_rises == 2) rise2_at = i;
      end
      prev_lval = vid.lval;
      prev_fval = vid.fval;
      if (i + 1 == en_off_at) vid.en = 1'b0;
      if (i + 1 == sel_at)    vid.sel = sel_new;
    end
  endtask

  task automatic start_frame(input logic [2:0] s);
    @(negedge clk);
    vid.en  = 1'b1;
    vid.sel = s;
  endtask

  initial begin
    rst     = 1'b1;
    vid.en  = 1'b0;
    vid.sel = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_fval", int'(vid.fval), 0);
    check("rst_lval", int'(vid.lval), 0);
    check("rst_pix",  int'(vid.pix_data), 0);
    check("rst_busy", int'(vid.busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_fval", int'(vid.fval), 0);
    check("idle_busy", int'(vid.busy), 0);

    // Single frame, gradient, one-cycle en pulse.
    start_frame(3'b010);
    watch(60, 1, -1, 3'b000);
    check("grad_fval_cycles", fval_cnt, 40);
    check("grad_bursts", bursts, 4);
    for (int l = 0; l < 4; l++) check($sformatf("grad_len%0d", l), g_len[l], 8);
    check("grad_done_cnt", done_cnt, 1);
    check("grad_done_at", done_at, 40);
    check("grad_busy_cycles", busy_cnt, 43);
    check("grad_zero_blank", zero_viol, 0);
    check("grad_dval_eq_lval", dval_viol, 0);
    exp_line = '{2, 3, 4, 5, 6, 7, 8, 9};
    check_line("grad_line2", 2, exp_line);
    exp_line = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_line("grad_line0", 0, exp_line);
    check("grad_idle_after", int'(vid.busy), 0);

    // Straps with BAR_W=2.
    start_frame(3'b000);
    watch(60, 1, -1, 3'b000);
    exp_line = '{0, 0, 32, 32, 64, 64, 96, 96};
    check_line("strap_line0", 0, exp_line);
    check_line("strap_line3", 3, exp_line);
    check("strap_fval_cycles", fval_cnt, 40);

    // Reserved select: full timing, all-zero pixels.
    start_frame(3'b101);
    watch(60, 1, -1, 3'b000);
    check("rsvd_fval_cycles", fval_cnt, 40);
    check("rsvd_bursts", bursts, 4);
    check("rsvd_done_cnt", done_cnt, 1);
    exp_line = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int l = 0; l < 4; l++) check_line($sformatf("rsvd_line%0d", l), l, exp_line);

    // Logo: (x-y) mod 64 < 8.
    start_frame(3'b111);
    watch(60, 1, -1, 3'b000);
    exp_line = '{64, 64, 255, 255, 255, 255, 255, 255};
    check_line("logo_line2", 2, exp_line);
    exp_line = '{255, 255, 255, 255, 255, 255, 255, 255};
    check_line("logo_line0", 0, exp_line);

    // Cubes: small x keeps x[6]^y[6]=0, so pixels follow y.
    start_frame(3'b110);
    watch(60, 1, -1, 3'b000);
    exp_line = '{3, 3, 3, 3, 3, 3, 3, 3};
    check_line("cubes_line3", 3, exp_line);

    // Back-to-back: checkers then choco_bar; sel change mid-frame 1, en
    // dropped mid-frame 2 must not truncate it.
    start_frame(3'b011);
    watch(100, 50, 10, 3'b001);
    check("b2b_fval_cycles", fval_cnt, 80);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_bursts", bursts, 8);
    check("b2b_vblank_gap", rise2_at - done_at, 3);
    check("b2b_period", rise2_at, 43);
    check("b2b_busy_cycles", busy_cnt, 86);
    exp_line = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_line("b2b_f1_line3", 3, exp_line);
    check_line("b2b_f2_line0", 4, exp_line);
    exp_line = '{32, 32, 32, 32, 32, 32, 32, 32};
    check_line("b2b_f2_line2", 6, exp_line);
    check_line("b2b_f2_line3", 7, exp_line);

    // Reset during line 2 aborts the frame.
    start_frame(3'b010);
    @(negedge clk);
    vid.en = 1'b0;
    repeat (22) @(negedge clk);
    check("abort_in_line", int'(vid.lval), 1);
    check("abort_pix_before", int'(vid.pix_data), 3);
    rst = 1'b1;
    #1;
    check("abort_fval", int'(vid.fval), 0);
    check("abort_lval", int'(vid.lval), 0);
    check("abort_dval", int'(vid.dval), 0);
    check("abort_pix",  int'(vid.pix_data), 0);
    check("abort_busy", int'(vid.busy), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(vid.frame_done), 0);
    end
    rst     = 1'b0;
    vid.en  = 1'b1;
    vid.sel = 3'b010;
    watch(60, 1, -1, 3'b000);
    check("restart_fval_cycles", fval_cnt, 40);
    check("restart_done_cnt", done_cnt, 1);
    exp_line = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_line("restart_line0", 0, exp_line);
    check("restart_line2_first", g_pix[2][0], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
